// File: rtl/writeback_unit_pkg.sv
// Shared encodings for the writeback stage: result-select, load funct3 and legal XLEN values.
package wb_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_IMM  = 2'b11
  } result_src_e;

  typedef enum logic [2:0] {
    LT_LB   = 3'b000,
    LT_LH   = 3'b001,
    LT_LW   = 3'b010,
    LT_LD   = 3'b011,
    LT_LBU  = 3'b100,
    LT_LHU  = 3'b101,
    LT_LWU  = 3'b110,
    LT_RSVD = 3'b111
  } load_type_e;

  localparam int unsigned XLEN_LEGAL_A = 32;
  localparam int unsigned XLEN_LEGAL_B = 64;

  function automatic bit xlen_legal(input int unsigned xlen);
    return (xlen == XLEN_LEGAL_A) || (xlen == XLEN_LEGAL_B);
  endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// M-to-W pipeline bundle plus W-stage outputs; master drives the stage, slave is the writeback unit.
interface writeback_unit_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
);
  logic              StallW;
  logic              FlushW;
  logic              ValidM;
  logic              RegWriteM;
  logic [REG_AW-1:0] RdM;
  logic [1:0]        ResultSrcM;
  logic [2:0]        LoadTypeM;
  logic [XLEN-1:0]   ALU_ResultM;
  logic [XLEN-1:0]   ReadDataM;
  logic [XLEN-1:0]   PCPlus4M;
  logic [XLEN-1:0]   ImmExtM;

  logic              ValidW;
  logic              RegWriteW;
  logic [REG_AW-1:0] RdW;
  logic [XLEN-1:0]   ResultW;

  modport master (
    output StallW, FlushW, ValidM, RegWriteM, RdM, ResultSrcM, LoadTypeM,
           ALU_ResultM, ReadDataM, PCPlus4M, ImmExtM,
    input  ValidW, RegWriteW, RdW, ResultW
  );

  modport slave (
    input  StallW, FlushW, ValidM, RegWriteM, RdM, ResultSrcM, LoadTypeM,
           ALU_ResultM, ReadDataM, PCPlus4M, ImmExtM,
    output ValidW, RegWriteW, RdW, ResultW
  );
endinterface

// File: rtl/writeback_unit_load_extend.sv
// Combinational load alignment and sign/zero extension of the raw aligned memory word.
module load_extend
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  load_type_e                    load_type_i,
  input  logic [$clog2(XLEN/8)-1:0]     offset_i,
  input  logic [XLEN-1:0]               rdata_i,
  output logic [XLEN-1:0]               data_o
);
  localparam int unsigned OB = $clog2(XLEN/8);

  logic [OB-1:0]   off;
  logic [XLEN-1:0] shifted;

  // LD masks the offset to zero, so shifted equals the raw word for LD (and LW/LWU at XLEN=32)
  always_comb begin
    off = offset_i;
    unique case (load_type_i)
      LT_LH, LT_LHU: off[0]   = 1'b0;
      LT_LW, LT_LWU: off[1:0] = 2'b00;
      LT_LD:         off      = '0;
      default:       off      = offset_i;
    endcase
    shifted = rdata_i >> {off, 3'b000};
  end

  always_comb begin
    data_o = rdata_i;
    unique case (load_type_i)
      LT_LB:   data_o = XLEN'($signed(shifted[7:0]));
      LT_LH:   data_o = XLEN'($signed(shifted[15:0]));
      LT_LW:   data_o = XLEN'($signed(shifted[31:0]));
      LT_LD:   data_o = shifted;
      LT_LBU:  data_o = XLEN'(shifted[7:0]);
      LT_LHU:  data_o = XLEN'(shifted[15:0]);
      LT_LWU:  data_o = XLEN'(shifted[31:0]);
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// W pipeline register with result select and load extension.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic             clk,
  input  logic             reset,
  writeback_unit_if.slave  wb
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]      RetireCount
`endif
);
  localparam int unsigned OB = $clog2(XLEN/8);

  if (!xlen_legal(XLEN)) begin : g_xlen_illegal
    $error("writeback_unit: XLEN must be 32 or 64");
  end

  logic              valid_q,    valid_d;
  logic              regwrite_q, regwrite_d;
  logic [REG_AW-1:0] rd_q,       rd_d;
  result_src_e       src_q,      src_d;
  load_type_e        lt_q,       lt_d;
  logic [XLEN-1:0]   alu_q,      alu_d;
  logic [XLEN-1:0]   rdata_q,    rdata_d;
  logic [XLEN-1:0]   pc4_q,      pc4_d;
  logic [XLEN-1:0]   imm_q,      imm_d;

  logic [XLEN-1:0]   load_data;
  logic [XLEN-1:0]   result;

  // Flush only drops the valid bit; payload fields hold so ResultW stays stable.
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    rd_d       = rd_q;
    src_d      = src_q;
    lt_d       = lt_q;
    alu_d      = alu_q;
    rdata_d    = rdata_q;
    pc4_d      = pc4_q;
    imm_d      = imm_q;
    if (wb.FlushW) begin
      valid_d = 1'b0;
    end else if (!wb.StallW) begin
      valid_d    = wb.ValidM;
      regwrite_d = wb.RegWriteM;
      rd_d       = wb.RdM;
      src_d      = result_src_e'(wb.ResultSrcM);
      lt_d       = load_type_e'(wb.LoadTypeM);
      alu_d      = wb.ALU_ResultM;
      rdata_d    = wb.ReadDataM;
      pc4_d      = wb.PCPlus4M;
      imm_d      = wb.ImmExtM;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      src_q      <= RES_ALU;
      lt_q       <= LT_LB;
      alu_q      <= '0;
      rdata_q    <= '0;
      pc4_q      <= '0;
      imm_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      src_q      <= src_d;
      lt_q       <= lt_d;
      alu_q      <= alu_d;
      rdata_q    <= rdata_d;
      pc4_q      <= pc4_d;
      imm_q      <= imm_d;
    end
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .load_type_i (lt_q),
    .offset_i    (alu_q[OB-1:0]),
    .rdata_i     (rdata_q),
    .data_o      (load_data)
  );

  always_comb begin
    result = alu_q;
    unique case (src_q)
      RES_ALU:  result = alu_q;
      RES_LOAD: result = load_data;
      RES_PC4:  result = pc4_q;
      RES_IMM:  result = imm_q;
      default:  result = alu_q;
    endcase
  end

  assign wb.ValidW    = valid_q;
  assign wb.RegWriteW = regwrite_q & valid_q & (rd_q != '0);
  assign wb.RdW       = rd_q;
  assign wb.ResultW   = result;

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_q, retire_d;

  always_comb begin
    retire_d = retire_q;
    if (valid_q && !wb.StallW) retire_d = retire_q + 64'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) retire_q <= '0;
    else       retire_q <= retire_d;
  end

  assign RetireCount = retire_q;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: XLEN=32 and XLEN=64 instances share one stimulus stream.
module tb_writeback_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  writeback_unit_if #(.XLEN(32), .REG_AW(5)) bus32 ();
  writeback_unit_if #(.XLEN(64), .REG_AW(5)) bus64 ();

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] rc32, rc64;
`endif

  writeback_unit #(.XLEN(32), .REG_AW(5)) dut32 (
    .clk   (clk),
    .reset (reset),
    .wb    (bus32)
`ifdef WB_RETIRE_CNT_EN
    , .RetireCount (rc32)
`endif
  );

  writeback_unit #(.XLEN(64), .REG_AW(5)) dut64 (
    .clk   (clk),
    .reset (reset),
    .wb    (bus64)
`ifdef WB_RETIRE_CNT_EN
    , .RetireCount (rc64)
`endif
  );

  typedef struct {
    logic        valid;
    logic        rw;
    logic [4:0]  rd;
    logic [63:0] r32;
    logic [63:0] r64;
    logic [63:0] cnt;
  } wstate_t;

  wstate_t m;
  wstate_t exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Load result from the byte-lane rules: natural alignment, width, sign, raw fallback.
  function automatic logic [63:0] ref_load(input int xlen, input logic [2:0] lt,
                                           input logic [63:0] alu, input logic [63:0] word);
    int n;
    bit sgn;
    int off;
    logic [63:0] w;
    logic [63:0] v;
    w = (xlen == 32) ? (word & 64'hFFFF_FFFF) : word;
    n = 0;
    sgn = 0;
    case (lt)
      3'd0: begin n = 1; sgn = 1; end
      3'd1: begin n = 2; sgn = 1; end
      3'd2: begin n = 4; sgn = 1; end
      3'd3: n = 8;
      3'd4: n = 1;
      3'd5: n = 2;
      3'd6: n = 4;
      default: n = 0;
    endcase
    if (n == 0 || n * 8 >= xlen) return w;
    off = int'(alu[5:0]) % (xlen / 8);
    off = off - (off % n);
    v = '0;
    for (int i = 0; i < n * 8; i++) v[i] = w[off * 8 + i];
    if (sgn && w[off * 8 + n * 8 - 1])
      for (int i = n * 8; i < xlen; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] ref_res(input int xlen, input logic [1:0] src, input logic [2:0] lt,
                                          input logic [63:0] alu, input logic [63:0] rdata,
                                          input logic [63:0] pc4, input logic [63:0] imm);
    logic [63:0] mask;
    mask = (xlen == 32) ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    case (src)
      2'd0: return alu & mask;
      2'd1: return ref_load(xlen, lt, alu, rdata);
      2'd2: return pc4 & mask;
      default: return imm & mask;
    endcase
  endfunction

  // Apply inputs at a negedge, advance the model over the coming posedge, wait for next negedge.
  task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] src,
                       input logic [2:0] lt, input logic [63:0] alu, input logic [63:0] rdata,
                       input logic [63:0] pc4, input logic [63:0] imm,
                       input logic stall, input logic flush);
    bus32.ValidM = v;  bus32.RegWriteM = rw; bus32.RdM = rd; bus32.ResultSrcM = src;
    bus32.LoadTypeM = lt; bus32.ALU_ResultM = alu[31:0]; bus32.ReadDataM = rdata[31:0];
    bus32.PCPlus4M = pc4[31:0]; bus32.ImmExtM = imm[31:0];
    bus32.StallW = stall; bus32.FlushW = flush;
    bus64.ValidM = v;  bus64.RegWriteM = rw; bus64.RdM = rd; bus64.ResultSrcM = src;
    bus64.LoadTypeM = lt; bus64.ALU_ResultM = alu; bus64.ReadDataM = rdata;
    bus64.PCPlus4M = pc4; bus64.ImmExtM = imm;
    bus64.StallW = stall; bus64.FlushW = flush;
    if (m.valid && !stall) m.cnt = m.cnt + 64'd1;
    if (flush) begin
      m.valid = 1'b0;
    end else if (!stall) begin
      m.valid = v;
      m.rw    = rw;
      m.rd    = rd;
      m.r32   = ref_res(32, src, lt, alu, rdata, pc4, imm);
      m.r64   = ref_res(64, src, lt, alu, rdata, pc4, imm);
    end
    exp_q.push_back(m);
    @(negedge clk);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic drive_random(input int n);
    for (int k = 0; k < n; k++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), 5'($urandom_range(0, 31)),
            2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), rnd64(), rnd64(), rnd64(), rnd64(),
            $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid32"}, {63'd0, bus32.ValidW}, 64'd0);
    check({tag, "_rw32"},    {63'd0, bus32.RegWriteW}, 64'd0);
    check({tag, "_rd32"},    {59'd0, bus32.RdW}, 64'd0);
    check({tag, "_res32"},   {32'd0, bus32.ResultW}, 64'd0);
    check({tag, "_valid64"}, {63'd0, bus64.ValidW}, 64'd0);
    check({tag, "_res64"},   bus64.ResultW, 64'd0);
`ifdef WB_RETIRE_CNT_EN
    check({tag, "_cnt32"}, rc32, 64'd0);
    check({tag, "_cnt64"}, rc64, 64'd0);
`endif
  endtask

  // Monitor: one expected W state per clock while the stimulus is running.
  always @(posedge clk) begin
    wstate_t e;
    logic erw;
    #1;
    if (!reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      erw = e.rw && e.valid && (e.rd != 5'd0);
      check("valid32", {63'd0, bus32.ValidW}, {63'd0, e.valid});
      check("regwr32", {63'd0, bus32.RegWriteW}, {63'd0, erw});
      check("rd32",    {59'd0, bus32.RdW}, {59'd0, e.rd});
      check("result32", {32'd0, bus32.ResultW}, e.r32);
      check("valid64", {63'd0, bus64.ValidW}, {63'd0, e.valid});
      check("regwr64", {63'd0, bus64.RegWriteW}, {63'd0, erw});
      check("rd64",    {59'd0, bus64.RdW}, {59'd0, e.rd});
      check("result64", bus64.ResultW, e.r64);
`ifdef WB_RETIRE_CNT_EN
      check("retire32", rc32, e.cnt);
      check("retire64", rc64, e.cnt);
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    m = '{valid: 1'b0, rw: 1'b0, rd: 5'd0, r32: 64'd0, r64: 64'd0, cnt: 64'd0};
    bus32.ValidM = 0; bus32.RegWriteM = 0; bus32.RdM = '0; bus32.ResultSrcM = '0;
    bus32.LoadTypeM = '0; bus32.ALU_ResultM = '0; bus32.ReadDataM = '0;
    bus32.PCPlus4M = '0; bus32.ImmExtM = '0;
    bus64.ValidM = 0; bus64.RegWriteM = 0; bus64.RdM = '0; bus64.ResultSrcM = '0;
    bus64.LoadTypeM = '0; bus64.ALU_ResultM = '0; bus64.ReadDataM = '0;
    bus64.PCPlus4M = '0; bus64.ImmExtM = '0;
    // Stall and flush held during reset: reset must win over both.
    bus32.StallW = 1; bus32.FlushW = 1; bus64.StallW = 1; bus64.FlushW = 1;
    #1;
    check_reset_outputs("rst_init");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst_held");
    @(negedge clk);
    reset = 1'b0;

    // Destination x0 never writes; x5 does.
    drive(1, 1, 5'd0, 2'd0, 3'd0, 64'h1234, '0, '0, '0, 0, 0);
    check("x0_regwrite", {63'd0, bus32.RegWriteW}, 64'd0);
    drive(1, 1, 5'd5, 2'd0, 3'd0, 64'h1234, '0, '0, '0, 0, 0);
    check("x5_regwrite", {63'd0, bus32.RegWriteW}, 64'd1);
    check("x5_rd", {59'd0, bus32.RdW}, 64'd5);

    drive(1, 1, 5'd3, 2'd1, 3'd0, 64'd3, 64'h1234_5678_80FF_7F01, '0, '0, 0, 0);
    check("lb_off3", {32'd0, bus32.ResultW}, 64'hFFFF_FF80);
    drive(1, 1, 5'd4, 2'd1, 3'd5, 64'd2, 64'h0000_0000_8001_1234, '0, '0, 0, 0);
    check("lhu_off2", {32'd0, bus32.ResultW}, 64'h0000_8001);
    drive(1, 1, 5'd4, 2'd1, 3'd5, 64'd3, 64'h0000_0000_8001_1234, '0, '0, 0, 0);
    check("lhu_off3", {32'd0, bus32.ResultW}, 64'h0000_8001);
    drive(1, 1, 5'd6, 2'd1, 3'd6, 64'd4, 64'hDEAD_BEEF_8000_0001, '0, '0, 0, 0);
    check("lwu64_off4", bus64.ResultW, 64'h0000_0000_DEAD_BEEF);
    check("lwu32_raw", {32'd0, bus32.ResultW}, 64'h8000_0001);
    drive(1, 1, 5'd8, 2'd2, 3'd0, '0, '0, 64'h1111_2222_3333_4444, '0, 0, 0);
    drive(1, 1, 5'd9, 2'd3, 3'd0, '0, '0, '0, 64'hFFFF_0000_ABCD_0123, 0, 0);

    // Hold for three stalled cycles, then flush while still stalled.
    drive(1, 1, 5'd7, 2'd0, 3'd0, 64'h0BAD_F00D, '0, '0, '0, 0, 0);
    for (int k = 0; k < 3; k++)
      drive(1, 1, 5'(10 + k), 2'd2, 3'd0, rnd64(), rnd64(), rnd64(), rnd64(), 1, 0);
    check("stall_hold_rd", {59'd0, bus32.RdW}, 64'd7);
    check("stall_hold_res", {32'd0, bus32.ResultW}, 64'h0BAD_F00D);
    drive(1, 1, 5'd12, 2'd0, 3'd0, 64'h55, '0, '0, '0, 1, 1);
    check("flush_valid", {63'd0, bus32.ValidW}, 64'd0);
    check("flush_regwrite", {63'd0, bus32.RegWriteW}, 64'd0);

`ifdef WB_RETIRE_CNT_EN
    drive(1, 1, 5'd1, 2'd0, 3'd0, 64'h1, '0, '0, '0, 0, 0);
    force dut32.retire_q = 64'hFFFF_FFFF_FFFF_FFFF;
    force dut64.retire_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut32.retire_q;
    release dut64.retire_q;
    m.cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    drive(1, 1, 5'd1, 2'd0, 3'd0, 64'h2, '0, '0, '0, 0, 0);
    check("retire_wrap", rc32, 64'd0);
`endif

    drive_random(300);

    // Reset arrives asynchronously in the middle of a stalled cycle.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    bus32.StallW = 1; bus64.StallW = 1;
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk);
    #1;
    check_reset_outputs("rst_mid_edge");
    @(negedge clk);
    reset = 1'b0;
    m = '{valid: 1'b0, rw: 1'b0, rd: 5'd0, r32: 64'd0, r64: 64'd0, cnt: 64'd0};
    drive(1, 1, 5'd17, 2'd3, 3'd0, '0, '0, '0, 64'h0000_0000_0000_0042, 0, 0);
    check("post_reset_capture", {32'd0, bus32.ResultW}, 64'h42);
    drive_random(100);

    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
